// File: rtl/add_sub_serial.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, result
// and carry-out are published together with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; s/cout hold the last result
// RUN   | shifting one operand bit per edge through the full adder
module add_sub_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic             sum_bit;
  logic             carry_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  // b_q already holds ~b for subtract; carry seeded with sel supplies the +1
  assign sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
  assign carry_bit = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    s_d     = s_q;
    c_d     = c_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sel ? ~b : b;
          c_d     = sel;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = carry_bit;
        sh_d  = {sum_bit, sh_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          s_d     = {sum_bit, sh_q[WIDTH-1:1]};
          cout_d  = carry_bit;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign done = done_q;
  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_add_sub_serial.sv
// Directed bench for add_sub_serial at WIDTH=4; inputs driven and outputs
// sampled on the falling edge.
module tb_add_sub_serial;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       sel;
  logic [3:0] s;
  logic       cout;
  logic       busy;
  logic       done;

  int pass_cnt;
  int total_cnt;

  add_sub_serial #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .sel  (sel),
    .s    (s),
    .cout (cout),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launches one operation, scrambles the inputs once it is latched, and
  // counts edges after the start edge until done (bounded at 12).
  task automatic do_op(input logic [3:0] av, input logic [3:0] bv, input logic sv,
                       output int lat, output bit s_moved, output int pulses);
    logic [3:0] s_before;
    @(negedge clk);
    a = av; b = bv; sel = sv; start = 1'b1;
    s_before = s;
    @(negedge clk);
    start = 1'b0; a = ~av; b = ~bv; sel = ~sv;
    lat = 0;
    s_moved = 1'b0;
    pulses = 0;
    while (!done && lat < 12) begin
      if (s !== s_before) s_moved = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (done) pulses = 1;
    @(negedge clk);
    if (done) pulses++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; sel = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({s, cout, busy, done} !== 7'b0) $display("FAIL reset_state got s=%0d cout=%0b busy=%0b done=%0b want all 0", s, cout, busy, done);
    else pass_cnt++;
    start = 1'b1; a = 4'd5; b = 4'd1;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_blocks_start got busy=%0b want 0", busy);
    else pass_cnt++;
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_vectors();
    logic [3:0] va [8] = '{4'd5, 4'd5, 4'd0, 4'd0, 4'd2, 4'd1, 4'd1, 4'd15};
    logic [3:0] vb [8] = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd2, 4'd5, 4'd5, 4'd1};
    logic       vs [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] es [8] = '{4'd6, 4'd4, 4'd0, 4'd0, 4'd0, 4'd6, 4'd12, 4'd0};
    logic       ec [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int lat, pulses;
    bit moved;
    for (int i = 0; i < 8; i++) begin
      do_op(va[i], vb[i], vs[i], lat, moved, pulses);
      total_cnt++;
      if (lat !== 4) $display("FAIL latency[%0d] got %0d want 4", i, lat);
      else pass_cnt++;
      total_cnt++;
      if (s !== es[i] || cout !== ec[i])
        $display("FAIL result[%0d] got s=%0d cout=%0b want s=%0d cout=%0b", i, s, cout, es[i], ec[i]);
      else pass_cnt++;
      total_cnt++;
      if (moved !== 1'b0 || pulses !== 1)
        $display("FAIL hold_pulse[%0d] got s_moved=%0b pulses=%0d want 0/1", i, moved, pulses);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_held();
    int pulses;
    @(negedge clk);
    a = 4'd5; b = 4'd1; sel = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 4'd9;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL held_busy got %0b want 1", busy);
    else pass_cnt++;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    total_cnt++;
    if (pulses !== 1 || s !== 4'd6 || cout !== 1'b0)
      $display("FAIL start_held got pulses=%0d s=%0d cout=%0b want 1/6/0", pulses, s, cout);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, pulses;
    bit moved, extra_done;
    do_op(4'd5, 4'd1, 1'b0, lat, moved, pulses);
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    // do_op ends one cycle past done, so relaunch the first op and catch done live
    @(negedge clk);
    a = 4'd5; b = 4'd1; sel = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    a = 4'd3; b = 4'd4; sel = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 4'd15; b = 4'd15;
    lat = 0; moved = 1'b0; extra_done = 1'b0;
    while (!done && lat < 12) begin
      if (s !== 4'd6) moved = 1'b1;
      @(negedge clk);
      lat++;
    end
    total_cnt++;
    if (lat !== 4) $display("FAIL b2b_latency got %0d want 4", lat);
    else pass_cnt++;
    total_cnt++;
    if (moved !== 1'b0) $display("FAIL b2b_hold s left 6 before second done");
    else pass_cnt++;
    total_cnt++;
    if (s !== 4'd7 || cout !== 1'b0) $display("FAIL b2b_result got s=%0d cout=%0b want 7/0", s, cout);
    else pass_cnt++;
    @(negedge clk);
    if (done) extra_done = 1'b1;
    total_cnt++;
    if (extra_done !== 1'b0) $display("FAIL b2b_done_width got done high for 2 cycles");
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    a = 4'd5; b = 4'd1; sel = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({s, cout, busy, done} !== 7'b0)
      $display("FAIL reset_mid got s=%0d cout=%0b busy=%0b done=%0b want all 0", s, cout, busy, done);
    else pass_cnt++;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    total_cnt++;
    if (pulses !== 0 || s !== 4'd0) $display("FAIL reset_abort got pulses=%0d s=%0d want 0/0", pulses, s);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_vectors();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
